// File: rtl/ysyx_23060201_mem_arbiter_if.sv
// Request/response channel between a memory master and a memory slave.
// The master modport issues requests and consumes responses; the slave
// modport accepts requests and produces responses.
interface ysyx_23060201_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     addr;
  logic              wen;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DW-1:0]     rdata;
  logic              resp_err;

  modport master (
    output req_valid, addr, wen, wdata, wmask, resp_ready,
    input  req_ready, resp_valid, rdata, resp_err
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wmask, resp_ready,
    output req_ready, resp_valid, rdata, resp_err
  );
endinterface

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Two-master / one-slave memory arbiter: IFU on m0, LSU on m1, one
// outstanding transaction, round-robin on ties.
module ysyx_23060201_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  ysyx_23060201_mem_arbiter_if.slave        m0,
  ysyx_23060201_mem_arbiter_if.slave        m1,
  ysyx_23060201_mem_arbiter_if.master       s,
  output logic                              busy_o
);
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic            owner_q;
  logic            last_grant_q;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [MW-1:0]   wmask_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;

  logic            grant0, grant1;
  logic            m_hs;
  logic            owner_resp_ready;

  // On a tie the master that did not win last time is preferred.
  assign grant0 = m0.req_valid & (~m1.req_valid | last_grant_q);
  assign grant1 = m1.req_valid & (~m0.req_valid | ~last_grant_q);
  // Ready is gated by reset so nothing is accepted while reset is held.
  assign m_hs   = rst_n_i & (state_q == IDLE) & (grant0 | grant1);
  assign owner_resp_ready = owner_q ? m1.resp_ready : m0.resp_ready;

  // Memory-side request fields always come straight from the latches.
  assign s.addr  = addr_q;
  assign s.wen   = wen_q;
  assign s.wdata = wdata_q;
  assign s.wmask = wmask_q;

  // State, owner and fairness bookkeeping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (m_hs) owner_q <= grant1;
      if (state_q == RESP && owner_resp_ready) last_grant_q <= owner_q;
    end
  end

  // Latch the granted request and the slave's response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (m_hs) begin
        addr_q  <= grant1 ? m1.addr  : m0.addr;
        wen_q   <= grant1 ? m1.wen   : m0.wen;
        wdata_q <= grant1 ? m1.wdata : m0.wdata;
        wmask_q <= grant1 ? m1.wmask : m0.wmask;
      end
      if (state_q == WAIT && s.resp_valid) begin
        rdata_q <= wen_q ? '0 : s.rdata;
        err_q   <= s.resp_err;
      end
    end
  end

  // Next-state and handshake outputs for the four-phase transaction.
  always_comb begin
    state_d       = state_q;
    m0.req_ready  = 1'b0;
    m1.req_ready  = 1'b0;
    m0.resp_valid = 1'b0;
    m1.resp_valid = 1'b0;
    m0.rdata      = '0;
    m1.rdata      = '0;
    m0.resp_err   = 1'b0;
    m1.resp_err   = 1'b0;
    s.req_valid   = 1'b0;
    s.resp_ready  = 1'b0;
    busy_o        = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        m0.req_ready = rst_n_i & grant0;
        m1.req_ready = rst_n_i & grant1;
        if (m_hs) state_d = SEND;
      end
      SEND: begin
        s.req_valid = 1'b1;
        if (s.req_ready) state_d = WAIT;
      end
      WAIT: begin
        s.resp_ready = 1'b1;
        if (s.resp_valid) state_d = RESP;
      end
      RESP: begin
        if (owner_q) begin
          m1.resp_valid = 1'b1;
          m1.rdata      = rdata_q;
          m1.resp_err   = err_q;
        end else begin
          m0.resp_valid = 1'b1;
          m0.rdata      = rdata_q;
          m0.resp_err   = err_q;
        end
        if (owner_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench for the two-master memory arbiter: the bench plays both
// masters and the memory slave cycle by cycle.
module tb_ysyx_23060201_mem_arbiter;
  logic clk;
  logic rst_n;
  logic busy;

  ysyx_23060201_mem_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
  ysyx_23060201_mem_arbiter_if #(.AW(32), .DW(32)) m1_bus ();
  ysyx_23060201_mem_arbiter_if #(.AW(32), .DW(32)) s_bus ();

  ysyx_23060201_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] t_addr  [2];
  logic        t_wen   [2];
  logic [31:0] t_wdata [2];
  logic [3:0]  t_wmask [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    m0_bus.addr  = t_addr[0];  m0_bus.wen = t_wen[0];
    m0_bus.wdata = t_wdata[0]; m0_bus.wmask = t_wmask[0];
    m1_bus.addr  = t_addr[1];  m1_bus.wen = t_wen[1];
    m1_bus.wdata = t_wdata[1]; m1_bus.wmask = t_wmask[1];
  endtask

  task automatic clear_slave();
    s_bus.req_ready  = 1'b0;
    s_bus.resp_valid = 1'b0;
    s_bus.rdata      = 32'h0;
    s_bus.resp_err   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},     32'(busy), 32'h0);
    check_val({tag, "_m0_ready"}, 32'(m0_bus.req_ready), 32'h0);
    check_val({tag, "_m1_ready"}, 32'(m1_bus.req_ready), 32'h0);
    check_val({tag, "_s_valid"},  32'(s_bus.req_valid), 32'h0);
    check_val({tag, "_s_rready"}, 32'(s_bus.resp_ready), 32'h0);
    check_val({tag, "_s_addr"},   s_bus.addr, 32'h0);
    check_val({tag, "_s_wdata"},  s_bus.wdata, 32'h0);
    check_val({tag, "_s_wmask"},  32'(s_bus.wmask), 32'h0);
    check_val({tag, "_s_wen"},    32'(s_bus.wen), 32'h0);
    check_val({tag, "_m0_rv"},    32'(m0_bus.resp_valid), 32'h0);
    check_val({tag, "_m1_rv"},    32'(m1_bus.resp_valid), 32'h0);
    check_val({tag, "_m0_rdata"}, m0_bus.rdata, 32'h0);
    check_val({tag, "_m1_rdata"}, m1_bus.rdata, 32'h0);
  endtask

  // Holds reset with both masters requesting; readies must stay low.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m0_bus.req_valid = 1'b1; m1_bus.req_valid = 1'b1;
    m0_bus.resp_ready = 1'b0; m1_bus.resp_ready = 1'b0;
    clear_slave();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero(tag);
    rst_n = 1'b1;
    m0_bus.req_valid = 1'b0; m1_bus.req_valid = 1'b0;
    $display("txn %s: reset applied and released", tag);
  endtask

  // One full transaction; entered and left at posedge+1.
  task automatic run_txn(input string tag, input logic v0, input logic v1, input int exp_own,
                         input int req_dly, input int resp_dly, input int bp_dly,
                         input logic [31:0] slv_rdata, input logic slv_err);
    logic [31:0] exp_rdata;
    logic [31:0] own_rdata, oth_rdata;
    logic        own_rv, oth_rv, own_err, oth_err;
    exp_rdata = t_wen[exp_own] ? 32'h0 : slv_rdata;
    drive_fields();
    m0_bus.req_valid = v0; m1_bus.req_valid = v1;
    m0_bus.resp_ready = 1'b0; m1_bus.resp_ready = 1'b0;
    clear_slave();
    #1;
    check_val({tag, "_idle_busy"}, 32'(busy), 32'h0);
    check_val({tag, "_m0_grant"}, 32'(m0_bus.req_ready), 32'(exp_own == 0));
    check_val({tag, "_m1_grant"}, 32'(m1_bus.req_ready), 32'(exp_own == 1));
    @(posedge clk); #1;
    if (exp_own == 0) m0_bus.req_valid = 1'b0; else m1_bus.req_valid = 1'b0;
    // SEND: a premature slave response is offered and must be ignored.
    for (int i = 0; i <= req_dly; i++) begin
      s_bus.req_ready  = (i == req_dly);
      s_bus.resp_valid = 1'b1;
      s_bus.rdata      = 32'hBAD0BAD0;
      #1;
      check_val({tag, "_send_valid"}, 32'(s_bus.req_valid), 32'h1);
      check_val({tag, "_send_rready"}, 32'(s_bus.resp_ready), 32'h0);
      check_val({tag, "_s_addr"},  s_bus.addr, t_addr[exp_own]);
      check_val({tag, "_s_wen"},   32'(s_bus.wen), 32'(t_wen[exp_own]));
      check_val({tag, "_s_wdata"}, s_bus.wdata, t_wdata[exp_own]);
      check_val({tag, "_s_wmask"}, 32'(s_bus.wmask), 32'(t_wmask[exp_own]));
      check_val({tag, "_send_m0_ready"}, 32'(m0_bus.req_ready), 32'h0);
      check_val({tag, "_send_m1_ready"}, 32'(m1_bus.req_ready), 32'h0);
      @(posedge clk); #1;
    end
    clear_slave();
    // WAIT: garbage on rdata/err until the response is valid.
    for (int i = 0; i <= resp_dly; i++) begin
      s_bus.resp_valid = (i == resp_dly);
      s_bus.rdata      = (i == resp_dly) ? slv_rdata : 32'hBAD1BAD1;
      s_bus.resp_err   = (i == resp_dly) ? slv_err : 1'b1;
      #1;
      check_val({tag, "_wait_rready"}, 32'(s_bus.resp_ready), 32'h1);
      check_val({tag, "_wait_valid"}, 32'(s_bus.req_valid), 32'h0);
      check_val({tag, "_wait_addr"}, s_bus.addr, t_addr[exp_own]);
      check_val({tag, "_wait_m0_rv"}, 32'(m0_bus.resp_valid), 32'h0);
      check_val({tag, "_wait_m1_rv"}, 32'(m1_bus.resp_valid), 32'h0);
      @(posedge clk); #1;
    end
    clear_slave();
    // RESP: the non-owner offers resp_ready, which must not complete it.
    for (int i = 0; i <= bp_dly; i++) begin
      if (exp_own == 0) begin
        m0_bus.resp_ready = (i == bp_dly); m1_bus.resp_ready = 1'b1;
      end else begin
        m1_bus.resp_ready = (i == bp_dly); m0_bus.resp_ready = 1'b1;
      end
      #1;
      own_rv    = (exp_own == 0) ? m0_bus.resp_valid : m1_bus.resp_valid;
      oth_rv    = (exp_own == 0) ? m1_bus.resp_valid : m0_bus.resp_valid;
      own_rdata = (exp_own == 0) ? m0_bus.rdata : m1_bus.rdata;
      oth_rdata = (exp_own == 0) ? m1_bus.rdata : m0_bus.rdata;
      own_err   = (exp_own == 0) ? m0_bus.resp_err : m1_bus.resp_err;
      oth_err   = (exp_own == 0) ? m1_bus.resp_err : m0_bus.resp_err;
      check_val({tag, "_resp_valid"}, 32'(own_rv), 32'h1);
      check_val({tag, "_resp_rdata"}, own_rdata, exp_rdata);
      check_val({tag, "_resp_err"},   32'(own_err), 32'(slv_err));
      check_val({tag, "_other_rv"},   32'(oth_rv), 32'h0);
      check_val({tag, "_other_rdata"}, oth_rdata, 32'h0);
      check_val({tag, "_other_err"},  32'(oth_err), 32'h0);
      check_val({tag, "_resp_m0_ready"}, 32'(m0_bus.req_ready), 32'h0);
      check_val({tag, "_resp_m1_ready"}, 32'(m1_bus.req_ready), 32'h0);
      check_val({tag, "_resp_busy"}, 32'(busy), 32'h1);
      @(posedge clk); #1;
    end
    m0_bus.resp_ready = 1'b0; m1_bus.resp_ready = 1'b0;
    check_val({tag, "_done_busy"}, 32'(busy), 32'h0);
    $display("txn %s: owner=m%0d addr=%h wen=%0d rdata=%h err=%0d",
             tag, exp_own, t_addr[exp_own], t_wen[exp_own], exp_rdata, slv_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    m0_bus.req_valid = 1'b0; m1_bus.req_valid = 1'b0;
    m0_bus.resp_ready = 1'b0; m1_bus.resp_ready = 1'b0;
    clear_slave();
    t_addr[0] = 32'h80000000; t_wen[0] = 1'b0; t_wdata[0] = 32'h0; t_wmask[0] = 4'h0;
    t_addr[1] = 32'h80002000; t_wen[1] = 1'b0; t_wdata[1] = 32'h0; t_wmask[1] = 4'h0;
    drive_fields();
    #2;
    @(posedge clk); #1;
    do_reset("rst0");

    // m0 alone, zero-wait slave: minimum latency path.
    run_txn("m0_read", 1'b1, 1'b0, 0, 0, 0, 0, 32'h00000413, 1'b0);

    // Ties after a fresh reset alternate starting with m0.
    do_reset("rst1");
    t_addr[0] = 32'h80000004;
    for (int k = 0; k < 6; k++)
      run_txn($sformatf("tie%0d", k), 1'b1, 1'b1, k % 2, 0, 0, 0, 32'h00001000 + k, 1'b0);

    // m1 write: response data must be zero whatever the slave returns.
    t_addr[1] = 32'h80001000; t_wen[1] = 1'b1; t_wdata[1] = 32'hDEADBEEF; t_wmask[1] = 4'hF;
    run_txn("m1_write", 1'b0, 1'b1, 1, 0, 0, 0, 32'h12345678, 1'b0);

    // Slave wait states and master back-pressure.
    t_addr[0] = 32'h80000100;
    run_txn("m0_stall", 1'b1, 1'b0, 0, 3, 2, 4, 32'hCAFEF00D, 1'b0);

    // Error on one response only.
    t_addr[0] = 32'h80000200;
    run_txn("m0_err", 1'b1, 1'b0, 0, 0, 0, 0, 32'h11111111, 1'b1);
    t_addr[0] = 32'h80000204;
    run_txn("m0_noerr", 1'b1, 1'b0, 0, 0, 0, 0, 32'h22222222, 1'b0);

    // Reset in WAIT: last grant was m0, so this tie goes to m1 first.
    t_addr[1] = 32'h80003000; t_wen[1] = 1'b0; t_wdata[1] = 32'h0; t_wmask[1] = 4'h0;
    drive_fields();
    m0_bus.req_valid = 1'b1; m1_bus.req_valid = 1'b1;
    #1;
    check_val("abort_m1_grant", 32'(m1_bus.req_ready), 32'h1);
    check_val("abort_m0_grant", 32'(m0_bus.req_ready), 32'h0);
    @(posedge clk); #1;
    m1_bus.req_valid = 1'b0;
    s_bus.req_ready = 1'b1;
    #1;
    check_val("abort_send", 32'(s_bus.req_valid), 32'h1);
    @(posedge clk); #1;
    s_bus.req_ready = 1'b0;
    #1;
    check_val("abort_wait_rready", 32'(s_bus.resp_ready), 32'h1);
    check_val("abort_wait_addr", s_bus.addr, 32'h80003000);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_async");
    $display("txn abort: reset asserted in WAIT");
    m0_bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_txn("post_abort_tie", 1'b1, 1'b1, 0, 0, 0, 0, 32'h33333333, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060201_mem_arbiter.md
# ysyx_23060201_mem_arbiter

Two-master, one-slave memory arbiter for the NPC core. It shares the single memory port between the instruction fetch path (master 0, IFU) and the load/store path (master 1, LSU). It sits between those units and the memory model, so the core can move from a combinational memory read to a handshaked, multi-cycle memory. Only one transaction is outstanding at a time. Ties are broken round-robin.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (wmask width = DW/8)

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- mN_req_valid  in  1  master N (N=0,1) request valid
- mN_req_ready  out  1  request accepted this cycle
- mN_addr  in  AW  byte address
- mN_wen  in  1  1=write, 0=read
- mN_wdata  in  DW  write data
- mN_wmask  in  DW/8  byte enables for writes
- mN_resp_valid  out  1  response valid to master N
- mN_resp_ready  in  1  master N accepts response
- mN_rdata  out  DW  read data (0 for writes)
- mN_resp_err  out  1  slave error for this transaction
- s_req_valid  out  1  request to memory
- s_req_ready  in  1  memory accepts request
- s_addr / s_wen / s_wdata / s_wmask  out  AW/1/DW/DW/8  registered request fields
- s_resp_valid  in  1  memory response valid
- s_resp_ready  out  1  arbiter accepts response
- s_rdata  in  DW  read data
- s_resp_err  in  1  memory error
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, SEND, WAIT, RESP. Registers: state, owner (1 bit), last_grant (1 bit), the latched request fields, and the latched rdata/err.
- IDLE:
  - Winner selection: if only one master has req_valid, it wins. If both do, the master != last_grant wins.
  - The winner's mN_req_ready is 1, combinational from the req_valid signals. The loser's ready is 0.
  - On handshake: latch addr/wen/wdata/wmask and owner=winner, then go to SEND.
- SEND: s_req_valid=1, driven from registers. On s_req_ready, go to WAIT.
- WAIT: s_resp_ready=1. On s_resp_valid, latch s_rdata (or 0 if the latched wen=1) and s_resp_err, then go to RESP.
- RESP:
  - m{owner}_resp_valid=1 with the latched rdata/err.
  - On m{owner}_resp_ready: last_grant<=owner, then go to IDLE.
- Outside IDLE, both mN_req_ready are 0. Outside RESP, both mN_resp_valid are 0.
- Masters must hold req_valid and its fields stable until ready. The arbiter never drops a held request.
- s_resp_valid is ignored in IDLE and SEND: the slave must not respond before its request is accepted.
- The non-owner master's rdata/err outputs are 0.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=1 (so master 0 wins the first tie), owner=0.
  - All latched fields are 0. All outputs are 0 except the combinational mN_req_ready, which is also 0 while rst=0.
- Minimum latency, with a zero-wait slave and an always-ready master:
  - Master handshake at cycle T.
  - s_req_valid at T+1.
  - s_resp_ready at T+2, with the slave responding at T+2.
  - mN_resp_valid at T+3.
  - Next grant at T+4.
- Slave wait states extend SEND or WAIT one cycle each. Master back-pressure extends RESP.
- Fairness: with both masters requesting continuously, grants strictly alternate, so no master waits more than one transaction.
- Reset mid-transaction aborts it immediately. No response is delivered, and the memory side must also be reset.
- Simultaneous events:
  - A new request in the same cycle as RESP completion is not granted until the next IDLE cycle.
  - s_req_ready and s_resp_valid arriving in the same SEND cycle: only s_req_ready is honoured.

## Test plan
- Reset then m0 only: m0 reads 0x80000000, slave returns 0x00000413 with zero wait. Required: m0_req_ready at T, s_req_valid at T+1 with s_addr=0x80000000, m0_resp_valid at T+3 with rdata=0x00000413, busy=0 at T+4.
- Tie after reset: m0 and m1 both valid. Required: m0 is granted first, m1 is granted on the next IDLE, and a second tie goes to m0 again (alternation over 6 transactions).
- m1 write to 0x80001000, wdata=0xDEADBEEF, wmask=0xF. Required: the s_* fields match, m1_rdata=0 in response, and m0_req_ready stays 0 throughout.
- Slave wait states (s_req_ready delayed 3 cycles, s_resp_valid delayed 2) and master back-pressure (resp_ready delayed 4). Required: s_addr and response data stay stable, and there is exactly one handshake per phase.
- s_resp_err=1 on an m0 read. Required: m0_resp_err=1 for that response only, and the next transaction reports err=0.
- Assert rst=0 while in WAIT. Required: outputs go to 0 asynchronously, and after release the first tie is granted to m0 again.
